// File: rtl/vnu_pkg.sv
// Shared decoder package: message widths and saturation bounds used by the
// variable-node unit, the check-node unit and the message-routing network.
package vnu_pkg;

    // Default code parameters for the decoder build
    localparam int unsigned DEG_DEF   = 3;
    localparam int unsigned RES_W_DEF = 8;
    localparam int unsigned EXT_W_DEF = 3;

    // Width of a q message: r precision plus the extra guard bits
    function automatic int unsigned data_w_f(input int unsigned res_w,
                                             input int unsigned ext_w);
        return res_w + ext_w;
    endfunction

    // Accumulator width that cannot overflow for llr plus deg messages
    function automatic int unsigned sum_w_f(input int unsigned data_w,
                                            input int unsigned deg);
        return data_w + int'($clog2(deg + 1)) + 1;
    endfunction

    // Positive saturation rail for a signed width w (symmetric range)
    function automatic longint sat_max_f(input int unsigned w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    localparam int unsigned DATA_W_DEF = data_w_f(RES_W_DEF, EXT_W_DEF);
    localparam int unsigned SUM_W_DEF  = sum_w_f(DATA_W_DEF, DEG_DEF);

endpackage : vnu_pkg

// File: rtl/vnu_sat.sv
// Symmetric signed saturation from IN_SIZE down to OUT_SIZE bits; the most
// negative OUT_SIZE code is never produced.
module sat
    import vnu_pkg::*;
#(
    parameter int unsigned IN_SIZE  = SUM_W_DEF,
    parameter int unsigned OUT_SIZE = DATA_W_DEF
) (
    input  logic signed [IN_SIZE-1:0]  din_i,
    output logic signed [OUT_SIZE-1:0] dout_c
);

    localparam logic signed [IN_SIZE-1:0] MAX_V = IN_SIZE'(sat_max_f(OUT_SIZE));
    localparam logic signed [IN_SIZE-1:0] MIN_V = -MAX_V;

    // Clamp to +/-MAX_V, otherwise pass the low bits through unchanged
    always_comb begin
        dout_c = OUT_SIZE'(din_i);
        if (din_i > MAX_V) begin
            dout_c = OUT_SIZE'(MAX_V);
        end else if (din_i < MIN_V) begin
            dout_c = OUT_SIZE'(MIN_V);
        end
    end

endmodule : sat

// File: rtl/vnu.sv
// Variable-node unit: sums the channel LLR with D check messages and returns
// D extrinsic messages plus a hard decision through a 2-stage pipeline.
module vnu
    import vnu_pkg::*;
#(
    parameter  int unsigned D      = DEG_DEF,
    parameter  int unsigned res_w  = RES_W_DEF,
    parameter  int unsigned ext_w  = EXT_W_DEF,
    localparam int unsigned data_w = data_w_f(res_w, ext_w),
    parameter  int unsigned llr_w  = data_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ld,
    input  logic [llr_w-1:0]      llr_in,
    input  logic                  init,
    input  logic [res_w*D-1:0]    r,
    output logic [data_w*D-1:0]   q,
    output logic                  hd,
    output logic                  vld
);

    localparam int unsigned sum_w = sum_w_f(data_w, D);

    logic signed [data_w-1:0] llr_q;
    logic signed [data_w-1:0] llr_op_c;
    logic signed [res_w-1:0]  rm_c [D];
    logic signed [sum_w-1:0]  total_d;

    logic signed [sum_w-1:0]  total_q;
    logic signed [res_w-1:0]  rm_q [D];

    logic signed [sum_w-1:0]  diff_c [D];
    logic signed [data_w-1:0] sat_c  [D];

    logic signed [data_w-1:0] q_q [D];
    logic                     hd_q;
    logic [1:0]               vld_q;

    // Channel LLR register, loaded sign-extended on accepted ld cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr_q <= '0;
        end else if (en && ld) begin
            llr_q <= data_w'($signed(llr_in));
        end
    end

    // Stage 1 operands: LLR bypass on ld, r masked on init, linear sum
    always_comb begin
        llr_op_c = ld ? data_w'($signed(llr_in)) : llr_q;
        total_d  = sum_w'(llr_op_c);
        for (int i = 0; i < int'(D); i++) begin
            rm_c[i] = init ? '0 : $signed(r[i*res_w +: res_w]);
            total_d = total_d + sum_w'(rm_c[i]);
        end
    end

    // Stage 1 register: total and the masked r values it was built from
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            for (int i = 0; i < int'(D); i++) begin
                rm_q[i] <= '0;
            end
        end else if (en) begin
            total_q <= total_d;
            for (int i = 0; i < int'(D); i++) begin
                rm_q[i] <= rm_c[i];
            end
        end
    end

    // Extrinsic difference per lane, exact in the accumulator width
    always_comb begin
        for (int i = 0; i < int'(D); i++) begin
            diff_c[i] = total_q - sum_w'(rm_q[i]);
        end
    end

    // One saturator per outgoing message
    for (genvar g = 0; g < int'(D); g++) begin : g_lane
        sat #(
            .IN_SIZE  (sum_w),
            .OUT_SIZE (data_w)
        ) u_sat (
            .din_i  (diff_c[g]),
            .dout_c (sat_c[g])
        );
    end

    // Stage 2 register: saturated messages, hard decision, valid shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(D); i++) begin
                q_q[i] <= '0;
            end
            hd_q  <= 1'b0;
            vld_q <= 2'b00;
        end else if (en) begin
            for (int i = 0; i < int'(D); i++) begin
                q_q[i] <= sat_c[i];
            end
            hd_q  <= total_q[sum_w-1];
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    // Pack registered lanes onto the q bus in the CNU input format
    always_comb begin
        q = '0;
        for (int i = 0; i < int'(D); i++) begin
            q[i*data_w +: data_w] = q_q[i];
        end
    end

    assign hd  = hd_q;
    assign vld = vld_q[1];

endmodule : vnu

// File: tb/tb_vnu.sv
// Self-checking bench for vnu: directed cases plus randomized traffic checked
// against an arithmetic reference of the node equations.
module tb_vnu;

    localparam int ND   = 3;
    localparam int RW   = 8;
    localparam int DW   = 11;
    localparam int LW   = 11;
    localparam int QMAX = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              ld;
    logic              init;
    logic [LW-1:0]     llr_in;
    logic [RW*ND-1:0]  r;
    logic [DW*ND-1:0]  q;
    logic              hd;
    logic              vld;

    always #5 clk = ~clk;

    vnu #(
        .D     (ND),
        .res_w (RW),
        .ext_w (3),
        .llr_w (LW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ld     (ld),
        .llr_in (llr_in),
        .init   (init),
        .r      (r),
        .q      (q),
        .hd     (hd),
        .vld    (vld)
    );

    typedef struct {
        int q [ND];
        int hd;
    } res_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_llr;
    int   m_vld;
    res_t m_out;
    res_t pend [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int x);
        if (x > QMAX)  return QMAX;
        if (x < -QMAX) return -QMAX;
        return x;
    endfunction

    function automatic int lane(input int i);
        logic signed [DW-1:0] v;
        v = q[i*DW +: DW];
        return int'(v);
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_llr = 0;
        m_vld = 0;
        m_out.hd = 0;
        for (int i = 0; i < ND; i++) m_out.q[i] = 0;
    endfunction

    // Node equations on plain integers; a result is visible one accepted
    // edge after the edge that accepted its inputs
    function automatic void model_accept(input bit l, input bit ini, input int llr,
                                         input int rv [ND]);
        int   op;
        int   tot;
        int   rm [ND];
        res_t res;
        op = l ? llr : m_llr;
        if (l) m_llr = llr;
        tot = op;
        for (int i = 0; i < ND; i++) begin
            rm[i] = ini ? 0 : rv[i];
            tot += rm[i];
        end
        for (int i = 0; i < ND; i++) res.q[i] = clamp(tot - rm[i]);
        res.hd = (tot < 0) ? 1 : 0;
        pend.push_back(res);
        if (pend.size() == 2) begin
            m_out = pend.pop_front();
            m_vld = 1;
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < ND; i++) chk($sformatf("%s.q%0d", tag, i), lane(i), m_out.q[i]);
        chk({tag, ".hd"},  int'(hd),  m_out.hd);
        chk({tag, ".vld"}, int'(vld), m_vld);
    endtask

    // Drive one cycle of inputs, clock it, update the model, check outputs
    task automatic cyc(input string tag, input bit e, input bit l, input bit ini,
                       input int llr, input int r0, input int r1, input int r2);
        int rv [ND];
        rv[0] = r0; rv[1] = r1; rv[2] = r2;
        en     = e;
        ld     = l;
        init   = ini;
        llr_in = LW'(llr);
        r      = {RW'(r2), RW'(r1), RW'(r0)};
        @(posedge clk);
        if (e) model_accept(l, ini, llr, rv);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".q0"},  lane(0),   0);
        chk({tag, ".q1"},  lane(1),   0);
        chk({tag, ".q2"},  lane(2),   0);
        chk({tag, ".hd"},  int'(hd),  0);
        chk({tag, ".vld"}, int'(vld), 0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        ld     = 1'b0;
        init   = 1'b0;
        llr_in = '0;
        r      = '0;
        model_reset();
        #2;
        chk("por.q0",  lane(0),   0);
        chk("por.hd",  int'(hd),  0);
        chk("por.vld", int'(vld), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Init load then a normal iteration on the stored LLR
        cyc("init",  1, 1, 1, 10, 99, -7, 3);
        cyc("iter",  1, 0, 0, 0, 5, -3, 20);
        chk("init_const.q0", lane(0), 10);
        chk("init_const.vld", int'(vld), 1);
        cyc("flush1", 1, 0, 0, 0, 0, 0, 0);
        chk("iter_const.q0", lane(0), 27);
        chk("iter_const.q1", lane(1), 35);
        chk("iter_const.q2", lane(2), 12);

        // Saturation on both rails
        cyc("satp", 1, 1, 0, 1023, 127, 127, 127);
        cyc("satn", 1, 1, 0, -1023, -128, -128, -128);
        chk("satp_const.q0", lane(0), 1023);
        cyc("flush2", 1, 0, 0, 0, 1, 2, 3);
        chk("satn_const.q2", lane(2), -1023);
        chk("satn_const.hd", int'(hd), 1);

        // Zero total gives hd = 0
        cyc("zero", 1, 1, 0, -4, 1, 1, 2);
        cyc("flush3", 1, 0, 0, 0, 0, 0, 0);
        chk("zero_const.q2", lane(2), -2);
        chk("zero_const.hd", int'(hd), 0);

        // Stall: en low for 3 cycles, ld ignored while stalled
        cyc("stA", 1, 1, 0, 50, 1, 2, 3);
        for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, -300, 9, 9, 9);
        cyc("stB", 1, 0, 0, 0, -10, 4, 7);
        cyc("stC", 1, 0, 0, 0, 0, 0, 0);

        // Reset mid-run, then LLR register must read back as 0
        pulse_reset("rst_mid");
        cyc("post1", 1, 0, 0, 0, 5, 6, 7);
        cyc("post2", 1, 0, 0, 0, 0, 0, 0);
        chk("post_const.q0", lane(0), 13);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                cyc("rnd",
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 2047)) - 1024,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_vnu

// File: doc/vnu.md
# vnu

Variable-node unit for the min-sum LDPC decoder, the counterpart of the check-node unit. The block holds the channel LLR of one code bit. It adds the D check-to-variable messages `r` from the attached check nodes and returns D extrinsic variable-to-check messages `q`, one to each check node, plus a hard decision bit. The datapath is a 2-stage enable-gated pipeline, and the `q` bus has the CNU's `q` input format.

## Interface
- `D`, default 3: variable-node degree, i.e. the number of r inputs and q outputs.
- `res_w`, default 8: width of each r message, signed two's complement.
- `ext_w`, default 3: extra bits of precision carried on q.
- `data_w`, localparam = res_w + ext_w: width of each q message, signed.
- `llr_w`, default data_w: channel LLR width, signed, with llr_w ≤ data_w.
- `sum_w`, localparam = data_w + $clog2(D+1) + 1: width of the internal accumulator.
- `clk`, in, 1: the single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: pipeline advance. When low, all registers hold.
- `ld`, in, 1: load `llr_in` into the LLR register. Acts only when `en`=1.
- `llr_in`, in, llr_w: channel LLR.
- `init`, in, 1: first iteration. `r` is treated as all-zero.
- `r`, in, res_w*D: check messages; lane i is `r[i*res_w +: res_w]`.
- `q`, out, data_w*D: variable messages; lane i is `q[i*data_w +: data_w]`.
- `hd`, out, 1: hard decision, 1 when the total is negative.
- `vld`, out, 1: `q` and `hd` hold the result of an accepted input.

## Operation
- An input is accepted in any cycle with `en`=1.
- LLR register:
  - Loads `llr_in` (sign-extended) on an accepted cycle with `ld`=1.
  - Otherwise holds its value.
- Stage 1 operand:
  - When `ld`=1 in the same cycle, stage 1 uses `llr_in` directly (bypass).
  - Otherwise it uses the stored LLR.
- Stage 1, registered:
  - total = llr + Σ r_i, with every term sign-extended to sum_w.
  - Each r_i is replaced by 0 when `init`=1.
  - The r_i values used, after `init` masking, are registered alongside total.
- Stage 2, registered:
  - q_i = sat(total − r_i).
  - hd = total[sum_w-1].
- Saturation:
  - Symmetric, to ±(2^(data_w-1) − 1).
  - −2^(data_w-1) is never produced.
  - Implemented with the existing `sat` block, IN_SIZE = sum_w, OUT_SIZE = data_w.
- hd = 0 when total is exactly 0.
- Accumulator width: sum_w guarantees no overflow for any input, so the only width loss is the final saturation.
- Subtraction of r_i is exact in sum_w.

## Timing
- Latency is 2 accepted cycles.
  - Input accepted at edge k gives `q`/`hd`/`vld` updated at edge k+2, provided `en`=1 at k+1.
- `vld` is a 2-bit shift of 1s.
  - It goes high on the second accepted edge after reset.
  - It stays high until the next reset.
- `en`=0 freezes everything: stage registers, the LLR register, `q`, `hd` and `vld` all hold. No bubbles are inserted.
- `ld`=1 with `en`=0 has no effect.
- Reset:
  - `q` = 0, `hd` = 0, `vld` = 0, LLR register = 0 and all stage registers = 0, immediately and asynchronously.
  - Reset mid-pipeline discards in-flight data.
  - The first accepted input after the `rst` falling edge starts a fresh 2-cycle latency.
- `init` and `ld` are sampled in the same accepted cycle as `r`, and apply to that input only.

## Structure
- The width localparams (data_w, sum_w) and the saturation bounds belong in a shared decoder package, also used by the CNU and the message-routing network.
- Sub-module: `sat`, one instance per lane. Everything else is inline: the adder tree, the subtractors and the pipeline registers.
- The adder tree is a plain linear sum, which is acceptable for D ≤ 6. It is not pipelined further.

## Test plan
- Reset: assert `rst` during a run with `vld`=1 → `q`=0, `hd`=0, `vld`=0 in the same cycle; LLR register reads back as 0 on the next `ld`=0 input.
- Init load: D=3, `en`=1, `ld`=1, `init`=1, `llr_in`=10, r={99,−7,3} → two edges later q={10,10,10}, `hd`=0, `vld`=1.
- Normal iteration: stored LLR 10, `init`=0, `ld`=0, r={5,−3,20} → total 32, q={27,35,12}, `hd`=0.
- Saturation both rails:
  - llr=1023, r={127,127,127} → q={1023,1023,1023}, `hd`=0.
  - llr=−1023, r={−128,−128,−128} → q={−1023,−1023,−1023}, `hd`=1.
- Stall: hold `en`=0 for 3 cycles between two accepted inputs → `q`/`vld` unchanged during the stall; the second result appears 2 enabled edges after its acceptance.
- Zero total: llr=−4, r={1,1,2} → total 0, q={−1,−1,−2}, `hd`=0.
